// File: rtl/led_trail_pwm.sv
`default_nettype none
// ============================================================================
// Module  : led_trail_pwm
// Brief   : PWM "comet tail" driver for a 16-bit one-hot LED word. Each LED
//           loads full brightness on input and decays in 16 steps.
//           Optional macro LED_TRAIL_GAMMA_EN selects a gamma duty table.
// Revision: 1.0 - initial release
// ============================================================================
module led_trail_pwm #(
  parameter int PWM_DIV       = 4,
  parameter int DECAY_DIV     = 1_000_000,
  parameter int IN_ACTIVE_LOW = 0
) (
  input  logic        clk100MHz,
  input  logic        reset,
  input  logic [15:0] led_in,
  input  logic        trail_en,
  output logic [15:0] led_out
);

  localparam int c_DCNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int c_PCNT_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [c_DCNT_W-1:0] c_DCNT_MAX = c_DCNT_W'(DECAY_DIV - 1);
  localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(PWM_DIV - 1);
  localparam logic [7:0]          c_PWM_MAX  = 8'd254;

  logic [15:0]         r_in_q;
  logic [3:0]          r_level [16];
  logic [c_DCNT_W-1:0] r_dcnt;
  logic [c_PCNT_W-1:0] r_pcnt;
  logic [7:0]          r_pwm_cnt;
  logic                w_decay_tick;
  logic                w_pcnt_wrap;
  logic [15:0]         w_pwm_on;

  assign w_decay_tick = (r_dcnt == c_DCNT_MAX);
  assign w_pcnt_wrap  = (r_pcnt == c_PCNT_MAX);

  function automatic logic [7:0] f_duty(input logic [3:0] lvl);
`ifdef LED_TRAIL_GAMMA_EN
    logic [7:0] v;
    case (lvl)
      4'd0:    v = 8'd0;
      4'd1:    v = 8'd1;
      4'd2:    v = 8'd3;
      4'd3:    v = 8'd7;
      4'd4:    v = 8'd14;
      4'd5:    v = 8'd23;
      4'd6:    v = 8'd34;
      4'd7:    v = 8'd48;
      4'd8:    v = 8'd64;
      4'd9:    v = 8'd83;
      4'd10:   v = 8'd105;
      4'd11:   v = 8'd129;
      4'd12:   v = 8'd156;
      4'd13:   v = 8'd186;
      4'd14:   v = 8'd219;
      default: v = 8'd255;
    endcase
    return v;
`else
    // level*17 is the level nibble replicated into both halves of the byte
    return {lvl, lvl};
`endif
  endfunction

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_duty
      assign w_pwm_on[gi] = (f_duty(r_level[gi]) > r_pwm_cnt);
    end
  endgenerate

  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      r_in_q <= 16'h0000;
    end else begin
      r_in_q <= (IN_ACTIVE_LOW != 0) ? ~led_in : led_in;
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      r_dcnt <= '0;
    end else if (w_decay_tick) begin
      r_dcnt <= '0;
    end else begin
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  // PWM period is 255 steps so level 15 (duty 255) stays on without a gap
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      r_pcnt    <= '0;
      r_pwm_cnt <= 8'd0;
    end else if (w_pcnt_wrap) begin
      r_pcnt    <= '0;
      r_pwm_cnt <= (r_pwm_cnt == c_PWM_MAX) ? 8'd0 : r_pwm_cnt + 8'd1;
    end else begin
      r_pcnt    <= r_pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk100MHz) begin
    for (int i = 0; i < 16; i++) begin
      if (reset) begin
        r_level[i] <= 4'd0;
      end else if (r_in_q[i]) begin
        r_level[i] <= 4'd15;
      end else if (w_decay_tick && (r_level[i] != 4'd0)) begin
        r_level[i] <= r_level[i] - 4'd1;
      end
    end
  end

  // Levels keep running in bypass so re-enabling shows the live trail
  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      led_out <= 16'h0000;
    end else if (trail_en) begin
      led_out <= w_pwm_on;
    end else begin
      led_out <= r_in_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_trail_pwm
// Brief   : Randomized scoreboard bench for led_trail_pwm (both polarities).
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_trail_pwm;

  localparam int PWM_DIV   = 1;
  localparam int DECAY_DIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] led_in;
  logic [15:0] led_in_n;
  logic        trail_en;
  logic [15:0] out_a;
  logic [15:0] out_b;

  always #5 clk = ~clk;
  assign led_in_n = ~led_in;

  led_trail_pwm #(.PWM_DIV(PWM_DIV), .DECAY_DIV(DECAY_DIV), .IN_ACTIVE_LOW(0)) u_dut_a (
    .clk100MHz(clk), .reset(rst), .led_in(led_in), .trail_en(trail_en), .led_out(out_a)
  );

  led_trail_pwm #(.PWM_DIV(PWM_DIV), .DECAY_DIV(DECAY_DIV), .IN_ACTIVE_LOW(1)) u_dut_b (
    .clk100MHz(clk), .reset(rst), .led_in(led_in_n), .trail_en(trail_en), .led_out(out_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  // Reference model: brightness per LED plus the edge count since reset,
  // from which both prescaled counters follow by plain arithmetic.
  int          m_lvl [16];
  logic [15:0] m_inq;
  int          m_n;
  int          gamma_tab [16] = '{0, 1, 3, 7, 14, 23, 34, 48, 64, 83, 105, 129, 156, 186, 219, 255};

  function automatic int duty_of(input int l);
`ifdef LED_TRAIL_GAMMA_EN
    return gamma_tab[l];
`else
    return l * 17;
`endif
  endfunction

  task automatic model_edge(input logic r, input logic [15:0] li, input logic te,
                            output logic [15:0] e);
    int  pwm_prev;
    bit  tick;
    if (r) begin
      for (int i = 0; i < 16; i++) m_lvl[i] = 0;
      m_inq = 16'h0000;
      m_n   = 0;
      e     = 16'h0000;
    end else begin
      m_n      = m_n + 1;
      tick     = (((m_n - 1) % DECAY_DIV) == DECAY_DIV - 1);
      pwm_prev = ((m_n - 1) / PWM_DIV) % 255;
      for (int i = 0; i < 16; i++)
        e[i] = te ? (duty_of(m_lvl[i]) > pwm_prev) : m_inq[i];
      for (int i = 0; i < 16; i++) begin
        if (m_inq[i])                m_lvl[i] = 15;
        else if (tick && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
      end
      m_inq = li;
    end
  endtask

  task automatic drive(input logic [15:0] li, input logic te, input logic r);
    logic [15:0] e;
    @(negedge clk);
    led_in   = li;
    trail_en = te;
    rst      = r;
    @(posedge clk);
    model_edge(r, li, te, e);
    exp_q.push_back(e);
  endtask

  // Monitor: one expected word per edge, checked half a cycle later
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_a !== e) begin
          errors++;
          $display("FAIL led_out_active_high t=%0t got %h want %h", $time, out_a, e);
        end
        checks++;
        if (out_b !== e) begin
          errors++;
          $display("FAIL led_out_active_low t=%0t got %h want %h", $time, out_b, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic te_r;
    logic [15:0] w;
    rst = 1'b1; led_in = 16'h0000; trail_en = 1'b1;

    // reset, some activity, reset again
    repeat (2) drive(16'($urandom), 1'b1, 1'b1);
    repeat (30) drive(16'($urandom), 1'b1, 1'b0);
    repeat (2) drive(16'h0000, 1'b1, 1'b1);

    // single pulse and full tail
    drive(16'h0001, 1'b1, 1'b0);
    repeat (140) drive(16'h0000, 1'b1, 1'b0);

    // walking one, 8 cycles per position
    for (int b = 0; b < 16; b++)
      repeat (8) drive(16'(1) << b, 1'b1, 1'b0);
    repeat (130) drive(16'h0000, 1'b1, 1'b0);

    // reset in the middle of a tail
    drive(16'hFFFF, 1'b1, 1'b0);
    repeat (20) drive(16'h0000, 1'b1, 1'b0);
    drive(16'h0000, 1'b1, 1'b1);
    repeat (10) drive(16'h0000, 1'b1, 1'b0);

    // bypass, then re-enable during the trail
    repeat (3) drive(16'hA5A5, 1'b0, 1'b0);
    repeat (10) drive(16'h0000, 1'b0, 1'b0);
    repeat (40) drive(16'h0000, 1'b1, 1'b0);

    // randomized traffic: mostly one-hot, sometimes arbitrary words
    te_r = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(63) == 0) te_r = ~te_r;
      case ($urandom_range(7))
        0, 1, 2: w = 16'(1) << $urandom_range(15);
        3:       w = 16'($urandom);
        default: w = 16'h0000;
      endcase
      drive(w, te_r, ($urandom_range(499) == 0));
    end
    repeat (150) drive(16'h0000, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_trail_pwm.md
# led_trail_pwm

Output stage placed directly downstream of the 4-to-16 waterfall decoder. It takes the decoder's 16-bit one-hot LED word and drives the board LEDs with a fading "comet tail":

- Each LED jumps to full brightness when its input bit asserts.
- It then decays in 16 PWM brightness steps after the bit deasserts.
- A bypass mode passes the registered input straight through.

## Interface

Parameters:
- PWM_DIV, default 4: system clocks per PWM counter step (100 MHz / 4 / 255 ≈ 98 kHz PWM).
- DECAY_DIV, default 1_000_000: system clocks per brightness decay step (10 ms; 150 ms full tail).
- IN_ACTIVE_LOW, default 0: 1 = led_in bits are active-low and are inverted at the input register.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk100MHz  in  1  system clock, 100 MHz.
- reset  in  1  synchronous active-high reset.
- led_in  in  16  decoder output word; one-hot expected, any pattern legal.
- trail_en  in  1  1 = fading trail mode, 0 = bypass.
- led_out  out  16  registered LED drive, active-high.

## Operation

- **Input register:** in_q <= IN_ACTIVE_LOW ? ~led_in : led_in, every cycle.
- **Brightness levels:** level[i] is 4-bit, one per LED.
- **Decay prescaler:** dcnt counts 0..DECAY_DIV-1 and wraps. decay_tick = (dcnt == DECAY_DIV-1).
- **Level update, per LED, in priority order:**
  - in_q[i]=1 → level[i] <= 15. Load wins over a simultaneous decay_tick.
  - else decay_tick and level[i]≠0 → level[i] <= level[i]-1.
  - else hold. Level saturates at 0 and never wraps.
- **PWM prescaler and counter:**
  - pcnt counts 0..PWM_DIV-1.
  - On pcnt wrap, pwm_cnt (8-bit) advances 0..254 and wraps 254→0. Period is 255 steps.
- **Duty mapping:**
  - Without the configuration macro (below): duty[i] = level[i]*17, giving 0..255.
  - Level 15 (duty 255) is always on; level 0 is always off.
- **Output:**
  - trail_en=1 → led_out[i] <= (duty[i] > pwm_cnt).
  - trail_en=0 → led_out <= in_q. Levels keep updating, so re-enabling shows the current trail state.
- Non-one-hot input is handled independently per bit, with no error.

## Timing

- **Reset** (registers take the reset value on the clock edge at which reset=1):
  - in_q=0, all levels=0, dcnt=0, pcnt=0, pwm_cnt=0, led_out=0x0000.
  - Reset mid-trail clears everything on the next edge.
  - led_out stays 0 while reset is held.
- **Trail mode latency:**
  - led_in sampled at edge k.
  - level=15 at edge k+1.
  - led_out bit high at edge k+2.
- **Bypass latency:** led_in sampled at edge k, led_out updated at edge k+1.
- **trail_en toggle:** takes effect at the next edge; no glitch-free requirement beyond registered output.
- **First decay step** after release occurs at the first decay_tick after level was last loaded. Tail length is therefore between 14·DECAY_DIV+1 and 15·DECAY_DIV clocks.
- **PWM duty at level L:** fraction of the pwm_cnt period with led_out high = duty/255, exact over one full 255·PWM_DIV-clock period.

## Configuration

- **LED_TRAIL_GAMMA_EN defined:** duty comes from a gamma (≈2.2) table indexed by level:
  - 0,1,3,7,14,23,34,48,64,83,105,129,156,186,219,255.
- **LED_TRAIL_GAMMA_EN undefined:** linear duty = level*17.
- All other behaviour is identical either way.

## Test plan

All scenarios use PWM_DIV=1, DECAY_DIV=8 unless stated.

1. **Reset:** any activity, then reset=1 for 2 cycles → led_out=0x0000, all levels 0, pwm_cnt=0; reset asserted mid-tail clears levels on the next edge.
2. **Single pulse:** led_in=0x0001 for 1 cycle, trail_en=1 → led_out[0]=1 at edge k+2 and continuously while level=15. Level reaches 0 after 15 decay ticks; thereafter led_out[0]=0 permanently. At level 8 (linear), led_out[0] is high for exactly 136 of 255 PWM cycles.
3. **Collision:** led_in[3] asserted so that in_q[3]=1 on a decay_tick edge → level[3]=15, not 14; saturation check: decay_tick at level 0 keeps 0.
4. **Walking one:** led_in shifts 0x0001→0x0002→…→0x8000, 8 cycles per step → the trailing LEDs hold levels 15,14,13,… in order behind the lit bit. At most 16 LEDs are nonzero, with no wrap of any level.
5. **Bypass and polarity:**
   - trail_en=0, led_in=0xA5A5 → led_out=0xA5A5 one edge later.
   - IN_ACTIVE_LOW=1 with led_in=0xFFFE → behaves as bit 0 asserted.
6. **Gamma:** LED_TRAIL_GAMMA_EN defined, level 8 → high for 64 of 255 PWM cycles; level 1 → 1 of 255; level 15 → always on.
